// File: rtl/axi_lite_register_file.sv
// AXI-Lite register bank: host read/write over aw/w/ar/r, parallel core view, core write port.
// Optional doorbell interrupt on host writes to register 0: AXI_LITE_REGFILE_DOORBELL_IRQ_EN.
module axi_lite_register_file #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 8
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        awaddr,
    input  logic                                 awvalid,
    output logic                                 awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      wstrb,
    input  logic                                 wvalid,
    output logic                                 wready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        araddr,
    input  logic                                 arvalid,
    output logic                                 arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        rdata,
    output logic                                 rvalid,
    input  logic                                 rready,
    input  logic                                 core_we,
    input  logic [$clog2(NUM_REGS)-1:0]          core_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        core_wdata,
`ifdef AXI_LITE_REGFILE_DOORBELL_IRQ_EN
    output logic                                 irq,
    input  logic                                 irq_ack,
`endif
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int IW       = $clog2(NUM_REGS);
    localparam int ADDR_LSB = $clog2(SW);

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_word,
                                                  input logic [DW-1:0] new_word,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] merged;
        merged = old_word;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic [DW-1:0] regs_r [NUM_REGS];
    logic          aw_full_r;
    logic [IW-1:0] aw_idx_r;
    logic          w_full_r;
    logic [DW-1:0] w_data_r;
    logic [SW-1:0] w_strb_r;
    logic          rvalid_r;
    logic [DW-1:0] rdata_r;

    logic          aw_hs_s;
    logic          w_hs_s;
    logic          ar_hs_s;
    logic          commit_s;
    logic [IW-1:0] ar_idx_s;
    logic          unused_addr_s;

    assign aw_hs_s  = awvalid && !aw_full_r;
    assign w_hs_s   = wvalid && !w_full_r;
    assign ar_hs_s  = arvalid && !rvalid_r;
    assign commit_s = aw_full_r && w_full_r;
    assign ar_idx_s = araddr[ADDR_LSB +: IW];
    // Upper address bits are deliberately ignored so that addresses alias.
    assign unused_addr_s = ^{awaddr, araddr};

    assign awready = !aw_full_r;
    assign wready  = !w_full_r;
    assign arready = !rvalid_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;

    // Write-address holding register; emptied by the commit.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full_r <= 1'b0;
            aw_idx_r  <= '0;
        end else if (commit_s) begin
            aw_full_r <= 1'b0;
        end else if (aw_hs_s) begin
            aw_full_r <= 1'b1;
            aw_idx_r  <= awaddr[ADDR_LSB +: IW];
        end
    end

    // Write-data holding register; emptied by the commit.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_full_r <= 1'b0;
            w_data_r <= '0;
            w_strb_r <= '0;
        end else if (commit_s) begin
            w_full_r <= 1'b0;
        end else if (w_hs_s) begin
            w_full_r <= 1'b1;
            w_data_r <= wdata;
            w_strb_r <= wstrb;
        end
    end

    // Register array update; the core port overrides a bus commit to the same index.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (core_we && (core_addr == IW'(i))) begin
                    regs_r[i] <= core_wdata;
                end else if (commit_s && (aw_idx_r == IW'(i))) begin
                    regs_r[i] <= apply_strb(regs_r[i], w_data_r, w_strb_r);
                end
            end
        end
    end

    // Read response; data is sampled at the AR handshake edge and held until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= regs_r[ar_idx_s];
        end else if (rvalid_r && rready) begin
            rvalid_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DW +: DW] = regs_r[g];
    end

`ifdef AXI_LITE_REGFILE_DOORBELL_IRQ_EN
    logic irq_pending_r;

    // Doorbell: a host commit to index 0 sets pending, and wins over a same-cycle ack.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            irq_pending_r <= 1'b0;
        end else if (commit_s && (aw_idx_r == IW'(0))) begin
            irq_pending_r <= 1'b1;
        end else if (irq_ack) begin
            irq_pending_r <= 1'b0;
        end
    end

    assign irq = irq_pending_r;
`endif

endmodule
